// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 32-iteration shift-add multiplier / restoring divider that owns HI/LO.
// Build option: define MULDIV_DIVIDE_EN to include the divider datapath (default: divide disabled).

module muldiv_sequencer (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Start,
    input  logic [1:0]  MdOp,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    input  logic        Flush,
    output logic        Busy,
    output logic        Stall,
    output logic        Done,
    output logic        DivZero,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        start_ok, fix_wr;
    logic [4:0]  count;
    logic        is_div, neg_res;
    logic [31:0] op_a;              // |multiplicand| or |dividend|
    logic [31:0] acc_hi, acc_lo;

    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs;
    logic [32:0] mul_sum;
    logic [31:0] mul_hi, mul_lo;
    logic [63:0] prod, prod_fix;

`ifdef MULDIV_DIVIDE_EN
    logic [31:0] divisor;
    logic        sign_a, div_zero;
    logic [32:0] rem_sh, diff;
    logic [31:0] div_hi, div_lo, quot_fix, rem_fix, orig_a;
`endif

    assign Busy  = (state != IDLE);
    assign Stall = Start | Busy;

    // Only MULT/DIV (MdOp[0]) take absolute values; unsigned operands pass through.
    assign a_neg = MdOp[0] & OpA[31];
    assign b_neg = MdOp[0] & OpB[31];
    assign a_abs = a_neg ? -OpA : OpA;
    assign b_abs = b_neg ? -OpB : OpB;

    // Shift-add step: add multiplicand into the upper half, then shift the 65-bit sum right.
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : 33'd0);
    assign mul_hi   = mul_sum[32:1];
    assign mul_lo   = {mul_sum[0], acc_lo[31:1]};
    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_res ? -prod : prod;

`ifdef MULDIV_DIVIDE_EN
    // Restoring step: the remainder stays below the divisor, so 32 bits hold it after the trial.
    assign rem_sh   = {acc_hi, acc_lo[31]};
    assign diff     = rem_sh - {1'b0, divisor};
    assign div_hi   = diff[32] ? rem_sh[31:0] : diff[31:0];
    assign div_lo   = {acc_lo[30:0], ~diff[32]};
    assign quot_fix = neg_res ? -acc_lo : acc_lo;
    assign rem_fix  = sign_a ? -acc_hi : acc_hi;
    assign orig_a   = sign_a ? -op_a : op_a;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        start_ok  = 1'b0;
        fix_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (Start && !Flush) begin
                    start_ok = 1'b1;
`ifdef MULDIV_DIVIDE_EN
                    state_nxt = RUN;
`else
                    state_nxt = MdOp[1] ? FIX : RUN;
`endif
                end
            end
            RUN: begin
                if (Flush)              state_nxt = IDLE;
                else if (count == 5'd31) state_nxt = FIX;
            end
            FIX: begin
                state_nxt = IDLE;
                fix_wr    = !Flush;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count    <= 5'd0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            op_a     <= 32'd0;
            acc_hi   <= 32'd0;
            acc_lo   <= 32'd0;
            Done     <= 1'b0;
            DivZero  <= 1'b0;
            HI       <= 32'd0;
            LO       <= 32'd0;
`ifdef MULDIV_DIVIDE_EN
            divisor  <= 32'd0;
            sign_a   <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            Done    <= 1'b0;
            DivZero <= 1'b0;
            if (start_ok) begin
                count   <= 5'd0;
                is_div  <= MdOp[1];
                neg_res <= a_neg ^ b_neg;
                op_a    <= a_abs;
                acc_hi  <= 32'd0;
                acc_lo  <= MdOp[1] ? a_abs : b_abs;
`ifdef MULDIV_DIVIDE_EN
                divisor  <= b_abs;
                sign_a   <= a_neg;
                div_zero <= (OpB == 32'd0);
`endif
            end else if (state == RUN) begin
                count <= count + 5'd1;
`ifdef MULDIV_DIVIDE_EN
                if (is_div) begin
                    acc_hi <= div_hi;
                    acc_lo <= div_lo;
                end else begin
                    acc_hi <= mul_hi;
                    acc_lo <= mul_lo;
                end
`else
                acc_hi <= mul_hi;
                acc_lo <= mul_lo;
`endif
            end

            if (fix_wr) begin
                Done <= 1'b1;
                if (is_div) begin
`ifdef MULDIV_DIVIDE_EN
                    if (div_zero) begin
                        LO      <= 32'hFFFF_FFFF;
                        HI      <= orig_a;
                        DivZero <= 1'b1;
                    end else begin
                        LO <= quot_fix;
                        HI <= rem_fix;
                    end
`else
                    LO <= 32'd0;
                    HI <= 32'd0;
`endif
                end else begin
                    HI <= prod_fix[63:32];
                    LO <= prod_fix[31:0];
                end
            end
        end
    end

endmodule
